pong_frame_ctrl: RTL and testbench

Per-frame game sequencer for Pong: computes paddle and ball positions and feeds the x1/y1, x2/y2, xb/yb inputs of the VGA driver. One update runs per video frame, started by the falling edge of the active-low vsync. The sequence is: paddles, ball move, wall bounce, paddle bounce, goal/score. All position outputs change atomically in one cycle, so the pixel generator never sees a half-updated frame.

---
 rtl/pong_pkg.sv | 54 +++++
 rtl/pong_frame_ctrl_if.sv | 37 +++
 rtl/pong_paddle_step.sv | 36 +++
 rtl/pong_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pong_frame_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong frame sequencer: screen/object geometry,
// sequencer states, direction encoding and small arithmetic helpers.
package pong_pkg;

  // Screen and object geometry
  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned PAD_W        = 8;
  localparam int unsigned PAD_H        = 64;
  localparam int unsigned BALL_SZ      = 8;
  localparam int unsigned PAD_SPEED    = 4;
  localparam int unsigned BALL_SPEED   = 2;
  localparam int unsigned P1_X         = 16;
  localparam int unsigned P2_X         = 616;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned MAX_SCORE    = 9;

  // Datapath widths
  localparam int unsigned COORD_W = 10;
  localparam int unsigned CALC_W  = 11;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned SERVE_W = 6;

  // Derived positions
  localparam int unsigned PAD_Y_MAX  = SCREEN_H - PAD_H;
  localparam int unsigned PAD_Y_RST  = PAD_Y_MAX / 2;
  localparam int unsigned BALL_X_MAX = SCREEN_W - BALL_SZ;
  localparam int unsigned BALL_Y_MAX = SCREEN_H - BALL_SZ;
  localparam int unsigned BALL_X_CTR = BALL_X_MAX / 2;
  localparam int unsigned BALL_Y_CTR = BALL_Y_MAX / 2;

  // Signed working coordinate so underflow shows up as a negative value
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef enum logic [2:0] {
    IDLE, PAD, MOVE, WALL, HIT, GOAL, COMMIT
  } state_e;

  // 0 = left/up, 1 = right/down
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  function automatic calc_t to_calc(input logic [COORD_W-1:0] v);
    return calc_t'({1'b0, v});
  endfunction

  // Score increment saturating at MAX_SCORE
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= SCORE_W'(MAX_SCORE)) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_frame_ctrl_if.sv
// Frame-control bus between the sequencer and its environment.
//   vsync, p1_up/dn, p2_up/dn : into the sequencer
//   x1/y1, x2/y2, xb/yb        : paddle and ball top-left positions
//   score1/score2, game_over   : game status
//   busy                       : update sequence in progress
interface pong_frame_ctrl_if;
  import pong_pkg::*;

  logic               vsync;
  logic               p1_up;
  logic               p1_dn;
  logic               p2_up;
  logic               p2_dn;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [COORD_W-1:0] xb;
  logic [COORD_W-1:0] yb;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               busy;

  // Sequencer side
  modport slave (
    input  vsync, p1_up, p1_dn, p2_up, p2_dn,
    output x1, y1, x2, y2, xb, yb, score1, score2, game_over, busy
  );

  // Sync generator / button / VGA driver side
  modport master (
    output vsync, p1_up, p1_dn, p2_up, p2_dn,
    input  x1, y1, x2, y2, xb, yb, score1, score2, game_over, busy
  );

endinterface

// File: rtl/pong_paddle_step.sv
// Combinational paddle step: move by PAD_SPEED on a lone up or down button,
// hold on both/neither, clamp to the visible range.
//   y_i        : current paddle top
//   up_i, dn_i : buttons
//   y_c_o      : next paddle top (combinational)
module pong_paddle_step
  import pong_pkg::*;
(
  input  logic [COORD_W-1:0] y_i,
  input  logic               up_i,
  input  logic               dn_i,
  output logic [COORD_W-1:0] y_c_o
);

  localparam calc_t Step = calc_t'(PAD_SPEED);
  localparam calc_t YMax = calc_t'(PAD_Y_MAX);

  calc_t y_sum;

  always_comb begin
    y_sum = to_calc(y_i);
    if (up_i && !dn_i) begin
      y_sum = y_sum - Step;
    end else if (dn_i && !up_i) begin
      y_sum = y_sum + Step;
    end

    y_c_o = y_sum[COORD_W-1:0];
    if (y_sum[CALC_W-1]) begin
      y_c_o = '0;
    end else if (y_sum > YMax) begin
      y_c_o = COORD_W'(PAD_Y_MAX);
    end
  end

endmodule

// File: rtl/pong_frame_ctrl.sv
// Per-frame Pong sequencer. On each vsync falling edge it steps paddles,
// moves the ball, resolves wall/paddle bounces and goals in working
// registers, then loads every visible output in a single COMMIT cycle.
//   clk, rst : clock, synchronous active-high reset
//   frame_if : slave side of pong_frame_ctrl_if (vsync/buttons in,
//              positions, scores, game_over, busy out)
module pong_frame_ctrl
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst,
  pong_frame_ctrl_if.slave frame_if
);

  localparam calc_t Zero     = calc_t'(0);
  localparam calc_t BallStep = calc_t'(BALL_SPEED);
  localparam calc_t BallSz   = calc_t'(BALL_SZ);
  localparam calc_t PadW     = calc_t'(PAD_W);
  localparam calc_t PadH     = calc_t'(PAD_H);
  localparam calc_t P1X      = calc_t'(P1_X);
  localparam calc_t P2X      = calc_t'(P2_X);
  localparam calc_t BallXMax = calc_t'(BALL_X_MAX);
  localparam calc_t BallYMax = calc_t'(BALL_Y_MAX);
  localparam calc_t BallXCtr = calc_t'(BALL_X_CTR);
  localparam calc_t BallYCtr = calc_t'(BALL_Y_CTR);

  state_e             state_q, state_d;
  logic               vs_d_q;
  logic               busy_q, busy_d;

  // Committed (visible) state
  logic [COORD_W-1:0] y1_q, y1_d, y2_q, y2_d, xb_q, xb_d, yb_q, yb_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               game_over_q, game_over_d;

  // Ball motion state and serve hold-off
  dir_e               dx_q, dx_d, dy_q, dy_d;
  logic [SERVE_W-1:0] serve_q, serve_d;

  // Working registers filled across the sequence
  logic [COORD_W-1:0] ny1_q, ny1_d, ny2_q, ny2_d;
  calc_t              nxb_q, nxb_d, nyb_q, nyb_d;
  logic [SCORE_W-1:0] nscore1_q, nscore1_d, nscore2_q, nscore2_d;
  logic               ngo_q, ngo_d;

  logic               frame_start_c;
  logic [COORD_W-1:0] ny1_c, ny2_c;
  logic               left_hit_c, right_hit_c;
  logic [SCORE_W-1:0] sc1_inc_c, sc2_inc_c;
  calc_t              ny1_s_c, ny2_s_c;

  assign frame_start_c = vs_d_q & ~frame_if.vsync;

  pong_paddle_step u_step1 (
    .y_i   (y1_q),
    .up_i  (frame_if.p1_up),
    .dn_i  (frame_if.p1_dn),
    .y_c_o (ny1_c)
  );

  pong_paddle_step u_step2 (
    .y_i   (y2_q),
    .up_i  (frame_if.p2_up),
    .dn_i  (frame_if.p2_dn),
    .y_c_o (ny2_c)
  );

  // Paddle overlap tests against the already-stepped paddle positions
  assign ny1_s_c = to_calc(ny1_q);
  assign ny2_s_c = to_calc(ny2_q);

  assign left_hit_c  = (dx_q == DIR_NEG) &&
                       (nxb_q <= P1X + PadW) && (nxb_q + BallSz > P1X) &&
                       (nyb_q + BallSz > ny1_s_c) && (nyb_q < ny1_s_c + PadH);

  assign right_hit_c = (dx_q == DIR_POS) &&
                       (nxb_q + BallSz >= P2X) && (nxb_q < P2X + PadW) &&
                       (nyb_q + BallSz > ny2_s_c) && (nyb_q < ny2_s_c + PadH);

  assign sc1_inc_c = score_inc(nscore1_q);
  assign sc2_inc_c = score_inc(nscore2_q);

  // Next-state and working-register update
  always_comb begin
    state_d     = state_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    xb_d        = xb_q;
    yb_d        = yb_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    game_over_d = game_over_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_d     = serve_q;
    ny1_d       = ny1_q;
    ny2_d       = ny2_q;
    nxb_d       = nxb_q;
    nyb_d       = nyb_q;
    nscore1_d   = nscore1_q;
    nscore2_d   = nscore2_q;
    ngo_d       = ngo_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start_c) state_d = PAD;
      end

      PAD: begin
        ny1_d     = ny1_c;
        ny2_d     = ny2_c;
        nscore1_d = score1_q;
        nscore2_d = score2_q;
        ngo_d     = game_over_q;
        state_d   = MOVE;
      end

      MOVE: begin
        if (game_over_q || (serve_q != '0)) begin
          if (!game_over_q) serve_d = serve_q - SERVE_W'(1);
          nxb_d   = BallXCtr;
          nyb_d   = BallYCtr;
          state_d = COMMIT;
        end else begin
          nxb_d   = (dx_q == DIR_POS) ? to_calc(xb_q) + BallStep : to_calc(xb_q) - BallStep;
          nyb_d   = (dy_q == DIR_POS) ? to_calc(yb_q) + BallStep : to_calc(yb_q) - BallStep;
          state_d = WALL;
        end
      end

      WALL: begin
        if (nyb_q <= Zero) begin
          nyb_d = Zero;
          dy_d  = DIR_POS;
        end else if (nyb_q >= BallYMax) begin
          nyb_d = BallYMax;
          dy_d  = DIR_NEG;
        end
        state_d = HIT;
      end

      HIT: begin
        // Snapped hit positions lie inside the field, so GOAL never fires after a hit
        if (left_hit_c) begin
          nxb_d = P1X + PadW;
          dx_d  = DIR_POS;
        end else if (right_hit_c) begin
          nxb_d = P2X - BallSz;
          dx_d  = DIR_NEG;
        end
        state_d = GOAL;
      end

      GOAL: begin
        if (nxb_q <= Zero) begin
          nscore2_d = sc2_inc_c;
          ngo_d     = ngo_q | (sc2_inc_c == SCORE_W'(MAX_SCORE));
          nxb_d     = BallXCtr;
          nyb_d     = BallYCtr;
          serve_d   = SERVE_W'(SERVE_FRAMES);
          dx_d      = DIR_NEG;
        end else if (nxb_q >= BallXMax) begin
          nscore1_d = sc1_inc_c;
          ngo_d     = ngo_q | (sc1_inc_c == SCORE_W'(MAX_SCORE));
          nxb_d     = BallXCtr;
          nyb_d     = BallYCtr;
          serve_d   = SERVE_W'(SERVE_FRAMES);
          dx_d      = DIR_POS;
        end
        state_d = COMMIT;
      end

      COMMIT: begin
        y1_d        = ny1_q;
        y2_d        = ny2_q;
        xb_d        = nxb_q[COORD_W-1:0];
        yb_d        = nyb_q[COORD_W-1:0];
        score1_d    = nscore1_q;
        score2_d    = nscore2_q;
        game_over_d = ngo_q;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_d_q      <= 1'b1;
      busy_q      <= 1'b0;
      y1_q        <= COORD_W'(PAD_Y_RST);
      y2_q        <= COORD_W'(PAD_Y_RST);
      xb_q        <= COORD_W'(BALL_X_CTR);
      yb_q        <= COORD_W'(BALL_Y_CTR);
      score1_q    <= '0;
      score2_q    <= '0;
      game_over_q <= 1'b0;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_POS;
      serve_q     <= SERVE_W'(SERVE_FRAMES);
      ny1_q       <= COORD_W'(PAD_Y_RST);
      ny2_q       <= COORD_W'(PAD_Y_RST);
      nxb_q       <= BallXCtr;
      nyb_q       <= BallYCtr;
      nscore1_q   <= '0;
      nscore2_q   <= '0;
      ngo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= frame_if.vsync;
      busy_q      <= busy_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      xb_q        <= xb_d;
      yb_q        <= yb_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_q     <= serve_d;
      ny1_q       <= ny1_d;
      ny2_q       <= ny2_d;
      nxb_q       <= nxb_d;
      nyb_q       <= nyb_d;
      nscore1_q   <= nscore1_d;
      nscore2_q   <= nscore2_d;
      ngo_q       <= ngo_d;
    end
  end

  assign frame_if.x1        = COORD_W'(P1_X);
  assign frame_if.x2        = COORD_W'(P2_X);
  assign frame_if.y1        = y1_q;
  assign frame_if.y2        = y2_q;
  assign frame_if.xb        = xb_q;
  assign frame_if.yb        = yb_q;
  assign frame_if.score1    = score1_q;
  assign frame_if.score2    = score2_q;
  assign frame_if.game_over = game_over_q;
  assign frame_if.busy      = busy_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Directed bench for pong_frame_ctrl: plays a scripted game through the
// buttons and checks hand-computed positions/scores at chosen frames.
module tb_pong_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   frame = 0;
  int   last_busy = 0;

  always #5 clk = ~clk;

  pong_frame_ctrl_if bus ();

  pong_frame_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .frame_if (bus.slave)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (frame %0d)", tag, got, exp, frame);
    end
  endtask

  task automatic check_ball(input string tag, input int exp_xb, input int exp_yb);
    check_val({tag, "_xb"}, int'(bus.xb), exp_xb);
    check_val({tag, "_yb"}, int'(bus.yb), exp_yb);
  endtask

  task automatic check_pads(input string tag, input int exp_y1, input int exp_y2);
    check_val({tag, "_y1"}, int'(bus.y1), exp_y1);
    check_val({tag, "_y2"}, int'(bus.y2), exp_y2);
  endtask

  task automatic check_score(input string tag, input int s1, input int s2, input int go);
    check_val({tag, "_s1"}, int'(bus.score1), s1);
    check_val({tag, "_s2"}, int'(bus.score2), s2);
    check_val({tag, "_go"}, int'(bus.game_over), go);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_x1"}, int'(bus.x1), 16);
    check_val({tag, "_x2"}, int'(bus.x2), 616);
    check_pads(tag, 208, 208);
    check_ball(tag, 316, 236);
    check_score(tag, 0, 0, 0);
    check_val({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // One vsync low pulse, then wait (bounded) for the sequence to finish
  task automatic do_frame();
    int cnt;
    @(posedge clk); #1 bus.vsync = 1'b0;
    @(posedge clk); #1 bus.vsync = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 20) check_val("frame_busy_bound", int'(bus.busy), 0);
    last_busy = cnt;
    frame++;
  endtask

  task automatic run_to(input int target);
    while (frame < target) do_frame();
  endtask

  task automatic set_btn(input logic u1, input logic d1, input logic u2, input logic d2);
    bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at frame %0d", frame);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    bus.vsync = 1'b1;
    set_btn(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Serve frames keep everything at reset values, short 3-cycle path
    do_frame();
    check_val("serve_busy_cycles", last_busy, 3);
    check_reset_vals("frame1");

    // Frame 2: p1 up alone, p2 both buttons
    set_btn(1, 0, 1, 1);
    do_frame();
    check_pads("both_btn", 204, 208);

    // p1 up and p2 down held through frame 62: clamp at both ends
    set_btn(1, 0, 0, 1);
    run_to(53);  check_pads("clamp_a", 0, 412);
    run_to(54);  check_pads("clamp_b", 0, 416);
    run_to(60);  check_ball("serve_end", 316, 236);
    run_to(61);  check_ball("first_move", 318, 238);
    run_to(62);  check_pads("clamp_hold", 0, 416);
    set_btn(0, 0, 0, 0);

    // Bottom wall bounce
    run_to(178); check_ball("bot_wall", 552, 472);
    run_to(179); check_ball("bot_after", 554, 470);

    // Right paddle hit against y2=416
    run_to(205); check_ball("rhit_pre", 606, 418);
    run_to(206); check_ball("rhit", 608, 416);
    run_to(207); check_ball("rhit_post", 606, 414);

    // Top wall bounce
    run_to(413); check_ball("top_pre", 194, 2);
    run_to(414); check_ball("top_wall", 192, 0);
    run_to(415); check_ball("top_post", 190, 2);

    // Left miss with y1=0: player 2 scores, serve toward the left
    run_to(509); check_ball("lgoal_pre", 2, 190);
    check_score("lgoal_pre", 0, 0, 0);
    run_to(510); check_ball("lgoal", 316, 236);
    check_score("lgoal", 0, 1, 0);

    // Move p1 to 416 during the serve
    run_to(519);
    set_btn(0, 1, 0, 0);
    run_to(570); check_ball("serve2_end", 316, 236);
    run_to(571); check_ball("serve2_move", 314, 238);
    run_to(623);
    set_btn(0, 0, 0, 0);
    check_pads("p1_down", 416, 416);

    // Left paddle hit
    run_to(715); check_ball("lhit_pre", 26, 418);
    run_to(716); check_ball("lhit", 24, 416);
    check_score("lhit", 0, 1, 0);
    run_to(717); check_ball("lhit_post", 26, 414);

    // Right miss: player 1 scores
    run_to(924);  check_ball("top2", 440, 0);
    run_to(1019); check_ball("rgoal_pre", 630, 190);
    run_to(1020); check_ball("rgoal", 316, 236);
    check_score("rgoal", 1, 1, 0);

    // Park p2 mid-screen so every later rally misses on the right
    run_to(1029);
    set_btn(0, 0, 1, 0);
    run_to(1081);
    set_btn(0, 0, 0, 0);
    check_pads("p2_mid", 416, 208);

    for (int k = 2; k <= 9; k++) begin
      g = 1020 + 218 * (k - 1);
      run_to(g - 1);
      check_val($sformatf("goal%0d_pre_xb", k), int'(bus.xb), 630);
      check_val($sformatf("goal%0d_pre_s1", k), int'(bus.score1), k - 1);
      run_to(g);
      check_ball($sformatf("goal%0d", k), 316, 236);
      check_score($sformatf("goal%0d", k), k, 1, (k == 9) ? 1 : 0);
    end

    // Game over: ball frozen, paddles still move
    set_btn(1, 0, 0, 0);
    run_to(2774);
    set_btn(0, 0, 0, 0);
    check_pads("go_pads", 376, 208);
    check_ball("go_ball", 316, 236);
    run_to(2830);
    check_val("go_busy_cycles", last_busy, 3);
    check_ball("go_frozen", 316, 236);
    check_score("go_final", 9, 1, 1);

    // Reset in the middle of a sequence
    @(posedge clk); #1 bus.vsync = 1'b0;
    @(posedge clk); #1 bus.vsync = 1'b1;
    @(posedge clk); #1;
    check_val("mid_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_vals("mid_rst");
    do_frame();
    check_val("post_rst_busy", last_busy, 3);
    check_reset_vals("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
